// File: rtl/mem_miss_arbiter_if.sv
// Miss request / memory request / response bundle between the caches, the
// miss arbiter and the memory hierarchy. The arbiter takes the slave side.
interface mem_miss_arbiter_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    parameter int ID_WIDTH   = $clog2(NUM_PORTS)
);
    logic [NUM_PORTS-1:0]            req_valid;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_PORTS-1:0]            req_is_store;
    logic [NUM_PORTS*LINE_WIDTH-1:0] req_data;
    logic [NUM_PORTS-1:0]            req_ready;

    logic                            mem_req_valid;
    logic                            mem_req_ready;
    logic [ADDR_WIDTH-1:0]           mem_req_addr;
    logic                            mem_req_is_store;
    logic [LINE_WIDTH-1:0]           mem_req_data;
    logic [ID_WIDTH-1:0]             mem_req_id;

    logic                            mem_rsp_valid;
    logic [LINE_WIDTH-1:0]           mem_rsp_data;
    logic [NUM_PORTS-1:0]            rsp_valid;
    logic [LINE_WIDTH-1:0]           rsp_data;
    logic                            rsp_error;

    modport master (
        output req_valid, req_addr, req_is_store, req_data,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  req_ready, mem_req_valid, mem_req_addr, mem_req_is_store,
        input  mem_req_data, mem_req_id, rsp_valid, rsp_data, rsp_error
    );

    modport slave (
        input  req_valid, req_addr, req_is_store, req_data,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output req_ready, mem_req_valid, mem_req_addr, mem_req_is_store,
        output mem_req_data, mem_req_id, rsp_valid, rsp_data, rsp_error
    );
endinterface

// File: rtl/mem_miss_arbiter.sv
// Round-robin arbiter of NUM_PORTS cache misses onto one registered memory port,
// with an in-order ID FIFO for response routing. MISS_ARB_PERF_CNT_EN adds perf counters.
module mem_miss_arbiter #(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_WIDTH  = 128,
    parameter int OUTSTANDING = 4,
    parameter int ID_WIDTH    = $clog2(NUM_PORTS)
) (
    input  logic                      clock,
    input  logic                      reset,
    mem_miss_arbiter_if.slave         bus
`ifdef MISS_ARB_PERF_CNT_EN
    ,
    output logic [NUM_PORTS*32-1:0]   perf_grant_cnt,
    output logic [31:0]               perf_full_stall_cnt
`endif
);
    localparam int PTR_W = $clog2(OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {IDLE, HOLD} state_t;

    state_t                state, state_nxt;
    logic [ID_WIDTH-1:0]   rr_ptr;
    logic [ID_WIDTH-1:0]   grant_idx;
    logic                  grant_found;
    logic                  grant;
    logic                  room;
    logic                  pop;
    logic [CNT_W-1:0]      count;
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [ID_WIDTH-1:0]   id_fifo [OUTSTANDING];
    logic [ID_WIDTH-1:0]   head_id;
    int unsigned           cand;

    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic                  req_is_store_q;
    logic [LINE_WIDTH-1:0] req_data_q;
    logic [ID_WIDTH-1:0]   req_id_q;
    logic                  rsp_error_q;

    // First valid port at or above rr_ptr, wrapping modulo NUM_PORTS.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            cand = (32'(rr_ptr) + i) % NUM_PORTS;
            if (!grant_found && bus.req_valid[ID_WIDTH'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = ID_WIDTH'(cand);
            end
        end
    end

    // Capacity uses the pre-pop count, so a full FIFO never grants on a response cycle.
    assign room = (count < CNT_W'(OUTSTANDING));

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found && room) begin
                    grant     = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (bus.mem_req_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign pop     = bus.mem_rsp_valid && (count != '0);
    assign head_id = id_fifo[rd_ptr];

    assign bus.req_ready        = (grant && reset) ? (NUM_PORTS'(1) << grant_idx) : '0;
    assign bus.rsp_valid        = (pop && reset) ? (NUM_PORTS'(1) << head_id) : '0;
    assign bus.rsp_data         = bus.mem_rsp_data;
    assign bus.mem_req_valid    = (state == HOLD);
    assign bus.mem_req_addr     = req_addr_q;
    assign bus.mem_req_is_store = req_is_store_q;
    assign bus.mem_req_data     = req_data_q;
    assign bus.mem_req_id       = req_id_q;
    assign bus.rsp_error        = rsp_error_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            count          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            req_addr_q     <= '0;
            req_is_store_q <= 1'b0;
            req_data_q     <= '0;
            req_id_q       <= '0;
            rsp_error_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                req_addr_q     <= bus.req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                req_is_store_q <= bus.req_is_store[grant_idx];
                req_data_q     <= bus.req_data[grant_idx*LINE_WIDTH +: LINE_WIDTH];
                req_id_q       <= grant_idx;
                rr_ptr         <= (grant_idx == ID_WIDTH'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(grant) - CNT_W'(pop);
            if (bus.mem_rsp_valid && (count == '0)) begin
                rsp_error_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (grant) begin
            id_fifo[wr_ptr] <= grant_idx;
        end
    end

`ifdef MISS_ARB_PERF_CNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_grant_cnt      <= '0;
            perf_full_stall_cnt <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (grant && (grant_idx == ID_WIDTH'(p)) && (perf_grant_cnt[p*32 +: 32] != '1)) begin
                    perf_grant_cnt[p*32 +: 32] <= perf_grant_cnt[p*32 +: 32] + 32'd1;
                end
            end
            if ((|bus.req_valid) && !room && (perf_full_stall_cnt != '1)) begin
                perf_full_stall_cnt <= perf_full_stall_cnt + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_mem_miss_arbiter.sv
// Scoreboard bench for mem_miss_arbiter: expected memory requests are queued as
// stimulus is driven and popped at each memory handshake; their ids route responses.
module tb_mem_miss_arbiter;
    localparam int NP   = 2;
    localparam int AW   = 32;
    localparam int LW   = 128;
    localparam int OUTS = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    mem_miss_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .ID_WIDTH(1)) bus ();
    mem_miss_arbiter_if #(.NUM_PORTS(3), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .ID_WIDTH(2)) bus3 ();

`ifdef MISS_ARB_PERF_CNT_EN
    logic [NP*32-1:0] perf_grant;
    logic [31:0]      perf_stall;
    logic [3*32-1:0]  perf_grant3;
    logic [31:0]      perf_stall3;
`endif

    mem_miss_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .OUTSTANDING(OUTS), .ID_WIDTH(1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef MISS_ARB_PERF_CNT_EN
        ,
        .perf_grant_cnt      (perf_grant),
        .perf_full_stall_cnt (perf_stall)
`endif
    );

    mem_miss_arbiter #(.NUM_PORTS(3), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .OUTSTANDING(OUTS), .ID_WIDTH(2)) dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (bus3)
`ifdef MISS_ARB_PERF_CNT_EN
        ,
        .perf_grant_cnt      (perf_grant3),
        .perf_full_stall_cnt (perf_stall3)
`endif
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic          store;
        logic [LW-1:0] data;
        int unsigned   id;
    } exp_t;

    exp_t          exp_req[$];
    int unsigned   exp_rsp[$];
    int unsigned   n_checks = 0;
    int unsigned   n_pass   = 0;
    logic [LW-1:0] rsp_line;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [LW-1:0] line_of(input logic [31:0] s);
        return {s, ~s, s ^ 32'h5A5A_5A5A, s + 32'd1};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_req(input int unsigned p, input logic [AW-1:0] a, input logic s, input logic [LW-1:0] d);
        bus.req_addr[p*AW +: AW] = a;
        bus.req_is_store[p]      = s;
        bus.req_data[p*LW +: LW] = d;
        bus.req_valid[p]         = 1'b1;
    endtask

    task automatic expect_req(input logic [AW-1:0] a, input logic s, input logic [LW-1:0] d, input int unsigned id);
        exp_t e;
        e.addr = a; e.store = s; e.data = d; e.id = id;
        exp_req.push_back(e);
    endtask

    task automatic await_grant(input int unsigned p, input string tag);
        bit seen;
        seen = 1'b0;
        for (int unsigned c = 0; c < 50 && !seen; c++) begin
            @(negedge clock);
            seen = bus.req_ready[p];
        end
        if (!seen) check(tag, 0, 1);
        tick();
        bus.req_valid[p] = 1'b0;
    endtask

    task automatic send_rsp(input logic [LW-1:0] d);
        rsp_line          = d;
        bus.mem_rsp_data  = d;
        bus.mem_rsp_valid = 1'b1;
        tick();
        bus.mem_rsp_valid = 1'b0;
    endtask

    // Scoreboard: memory handshakes pop expected requests, responses pop expected ids.
    exp_t          mon_e;
    int unsigned   mon_id;
    logic [NP-1:0] mon_oh;
    always @(negedge clock) begin
        if (reset) begin
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                if (exp_req.size() == 0) begin
                    check("mreq_unexpected", 1, 0);
                end else begin
                    mon_e = exp_req.pop_front();
                    check("mreq_addr",  bus.mem_req_addr,     mon_e.addr);
                    check("mreq_store", bus.mem_req_is_store, mon_e.store);
                    check("mreq_data",  bus.mem_req_data,     mon_e.data);
                    check("mreq_id",    bus.mem_req_id,       LW'(mon_e.id));
                    exp_rsp.push_back(mon_e.id);
                end
            end
            if (bus.mem_rsp_valid) begin
                if (exp_rsp.size() != 0) begin
                    mon_id = exp_rsp.pop_front();
                    mon_oh = NP'(1) << mon_id;
                    check("rsp_route", bus.rsp_valid, mon_oh);
                    check("rsp_data",  bus.rsp_data,  rsp_line);
                end else begin
                    check("rsp_drop", bus.rsp_valid, 0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid     = '1;
        bus.req_addr      = '0;
        bus.req_is_store  = '0;
        bus.req_data      = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        rsp_line          = '0;
        bus3.req_valid     = '0;
        bus3.req_addr      = '0;
        bus3.req_is_store  = '0;
        bus3.req_data      = '0;
        bus3.mem_req_ready = 1'b1;
        bus3.mem_rsp_valid = 1'b0;
        bus3.mem_rsp_data  = '0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_req_ready",  bus.req_ready,     0);
        check("rst_mreq_valid", bus.mem_req_valid, 0);
        check("rst_mreq_addr",  bus.mem_req_addr,  0);
        check("rst_mreq_data",  bus.mem_req_data,  0);
        check("rst_mreq_id",    bus.mem_req_id,    0);
        check("rst_rsp_error",  bus.rsp_error,     0);
        bus.req_valid = '0;
        @(negedge clock);
        #2 reset = 1'b1;
        tick();

        // Single request from port 1
        bus.mem_req_ready = 1'b1;
        expect_req(32'h0000_1040, 1'b0, '0, 1);
        drive_req(1, 32'h0000_1040, 1'b0, '0);
        @(negedge clock);
        check("t1_req_ready", bus.req_ready, 2'b10);
        tick();
        bus.req_valid[1] = 1'b0;
        @(negedge clock);
        check("t1_mreq_valid", bus.mem_req_valid, 1);
        tick();
        @(negedge clock);
        check("t1_mreq_idle", bus.mem_req_valid, 0);
        tick();
        rsp_line          = {4{32'hAAAA_AAAA}};
        bus.mem_rsp_data  = rsp_line;
        bus.mem_rsp_valid = 1'b1;
        @(negedge clock);
        check("t1_rsp_valid", bus.rsp_valid, 2'b10);
        tick();
        bus.mem_rsp_valid = 1'b0;

        // Round-robin with both ports continuously requesting
        for (int unsigned k = 0; k < 2; k++) begin
            expect_req(32'h2000 + k*64, 1'b0, line_of(10 + k), 0);
            expect_req(32'h3000 + k*64, 1'b1, line_of(20 + k), 1);
        end
        fork
            begin
                for (int unsigned k = 0; k < 2; k++) begin
                    drive_req(0, 32'h2000 + k*64, 1'b0, line_of(10 + k));
                    await_grant(0, "rr_timeout_p0");
                end
            end
            begin
                for (int unsigned k = 0; k < 2; k++) begin
                    drive_req(1, 32'h3000 + k*64, 1'b1, line_of(20 + k));
                    await_grant(1, "rr_timeout_p1");
                end
            end
        join
        repeat (2) tick();
        for (int unsigned k = 0; k < 4; k++) send_rsp(line_of(100 + k));

        // Backpressure: memory stalls 5 cycles after the grant
        bus.mem_req_ready = 1'b0;
        expect_req(32'h5000, 1'b1, line_of(50), 0);
        expect_req(32'h5100, 1'b0, line_of(51), 1);
        drive_req(0, 32'h5000, 1'b1, line_of(50));
        drive_req(1, 32'h5100, 1'b0, line_of(51));
        @(negedge clock);
        check("bp_grant", bus.req_ready, 2'b01);
        tick();
        bus.req_valid[0] = 1'b0;
        for (int unsigned c = 0; c < 5; c++) begin
            @(negedge clock);
            check("bp_hold_valid", bus.mem_req_valid, 1);
            check("bp_hold_addr",  bus.mem_req_addr,  32'h5000);
            check("bp_no_grant",   bus.req_ready,     0);
            tick();
        end
        bus.mem_req_ready = 1'b1;
        @(negedge clock);
        check("bp_accept_cycle", bus.req_ready, 0);
        tick();
        @(negedge clock);
        check("bp_next_grant", bus.req_ready, 2'b10);
        tick();
        bus.req_valid[1] = 1'b0;
        tick();
        send_rsp(line_of(60));
        send_rsp(line_of(61));

        // FIFO full: four outstanding, fifth waits for a response
        for (int unsigned k = 0; k < 4; k++) begin
            expect_req(32'h7000 + k*64, 1'b0, line_of(70 + k), 0);
            drive_req(0, 32'h7000 + k*64, 1'b0, line_of(70 + k));
            await_grant(0, "full_fill_timeout");
        end
        expect_req(32'h8000, 1'b1, line_of(80), 1);
        drive_req(1, 32'h8000, 1'b1, line_of(80));
        for (int unsigned c = 0; c < 4; c++) begin
            @(negedge clock);
            check("full_blocked", bus.req_ready, 0);
            tick();
        end
        rsp_line          = line_of(90);
        bus.mem_rsp_data  = rsp_line;
        bus.mem_rsp_valid = 1'b1;
        @(negedge clock);
        check("full_rsp_same_cycle", bus.req_ready, 0);
        tick();
        bus.mem_rsp_valid = 1'b0;
        @(negedge clock);
        check("full_freed_grant", bus.req_ready, 2'b10);
        tick();
        bus.req_valid[1] = 1'b0;
        tick();
        for (int unsigned k = 0; k < 4; k++) send_rsp(line_of(91 + k));

        // Spurious response with nothing outstanding
        rsp_line          = line_of(99);
        bus.mem_rsp_data  = rsp_line;
        bus.mem_rsp_valid = 1'b1;
        @(negedge clock);
        check("spur_rsp_valid", bus.rsp_valid, 0);
        check("spur_err_before", bus.rsp_error, 0);
        tick();
        bus.mem_rsp_valid = 1'b0;
        @(negedge clock);
        check("spur_err_set", bus.rsp_error, 1);
        repeat (2) tick();
        @(negedge clock);
        check("spur_err_sticky", bus.rsp_error, 1);
        tick();
        reset = 1'b0;
        #1;
        check("async_rst_err", bus.rsp_error, 0);
        bus.req_valid     = 2'b01;
        bus.mem_rsp_valid = 1'b1;
        #1;
        check("rst_gate_ready", bus.req_ready, 0);
        check("rst_gate_rsp",   bus.rsp_valid, 0);
        bus.req_valid     = '0;
        bus.mem_rsp_valid = 1'b0;
        @(negedge clock);
        #2 reset = 1'b1;
        tick();

        // Three ports: rr_ptr=1 with ports 0 and 2 valid
        bus3.req_addr[0 +: AW] = 32'h4000;
        bus3.req_valid         = 3'b001;
        @(negedge clock);
        check("np3_first", bus3.req_ready, 3'b001);
        tick();
        bus3.req_addr[2*AW +: AW] = 32'h6000;
        bus3.req_valid            = 3'b101;
        @(negedge clock);
        check("np3_hold", bus3.req_ready, 0);
        tick();
        @(negedge clock);
        check("np3_rr_p2", bus3.req_ready, 3'b100);
        tick();
        bus3.req_valid[2] = 1'b0;
        @(negedge clock);
        check("np3_id",   bus3.mem_req_id,   2);
        check("np3_addr", bus3.mem_req_addr, 32'h6000);
        tick();
        @(negedge clock);
        check("np3_rr_p0", bus3.req_ready, 3'b001);
        tick();
        bus3.req_valid = '0;

        check("exp_req_drained", exp_req.size(), 0);
        check("exp_rsp_drained", exp_rsp.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_miss_arbiter.md
Name: mem_miss_arbiter

Overview:
- Parametrised successor to the core's fixed two-client miss interface, where I$ and D$ misses share one memory port and responses are steered by a single 1-bit cache id.
- Arbitrates NUM_PORTS cache miss requesters onto one registered memory request channel using round-robin.
- Tracks outstanding requests in an in-order ID FIFO and routes each memory response back to the port that issued it.
- Sits between the cache stages and the memory hierarchy at the core top.

Parameters:
- NUM_PORTS, 2, number of requesting caches; must be ≥2.
- ADDR_WIDTH, 32, request address width.
- LINE_WIDTH, 128, cache line width for store data and response data.
- OUTSTANDING, 4, maximum requests issued without a response; must be a power of two, ≥2.
- ID_WIDTH, $clog2(NUM_PORTS), width of the port index.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  NUM_PORTS  per-port miss request valid.
- req_addr  in  NUM_PORTS*ADDR_WIDTH  per-port line address, port p at [p*ADDR_WIDTH +: ADDR_WIDTH].
- req_is_store  in  NUM_PORTS  per-port write (eviction) flag.
- req_data  in  NUM_PORTS*LINE_WIDTH  per-port store line.
- req_ready  out  NUM_PORTS  one-hot accept pulse; the request is consumed in that cycle.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  ADDR_WIDTH  registered address.
- mem_req_is_store  out  1  registered store flag.
- mem_req_data  out  LINE_WIDTH  registered store line.
- mem_req_id  out  ID_WIDTH  index of the granted port.
- mem_rsp_valid  in  1  memory response valid; responses return in request order, one per request.
- mem_rsp_data  in  LINE_WIDTH  response line.
- rsp_valid  out  NUM_PORTS  one-hot routed response valid.
- rsp_data  out  LINE_WIDTH  response data, passed through to all ports.
- rsp_error  out  1  sticky flag: a response arrived with no outstanding request.

Behaviour:
- Reset values: mem_req_valid=0, mem_req_addr=0, mem_req_is_store=0, mem_req_data=0, mem_req_id=0, rsp_error=0, FIFO empty (count=0), FSM=IDLE, rr_ptr=0.
- req_ready and rsp_valid are combinational and 0 while reset is asserted.
- FSM IDLE:
  - If any req_valid is set and count<OUTSTANDING, grant the first valid port searching upward from rr_ptr, modulo NUM_PORTS.
  - Same cycle: req_ready[g]=1; capture addr, is_store, data and id=g into the output registers; push g into the ID FIFO; rr_ptr<=(g+1) mod NUM_PORTS.
  - Next state is HOLD.
- FSM HOLD:
  - mem_req_valid=1 and all mem_req_* fields stay stable.
  - When mem_req_ready=1, go to IDLE, with mem_req_valid=0 from the next cycle.
- Timing and throughput:
  - Request accepted in cycle N gives mem_req_valid from N+1.
  - Peak throughput is one request per two cycles.
- FIFO full (count==OUTSTANDING): no grant; req_ready=0; requesters wait.
- Response routing: when mem_rsp_valid=1 and count>0:
  - rsp_valid[fifo_head]=1 combinationally, rsp_data=mem_rsp_data.
  - The head is popped at the clock edge.
- Simultaneous push and pop: count is unchanged; pointers wrap modulo OUTSTANDING.
- Full plus response in the same cycle: no grant that cycle, since the capacity check uses the pre-pop count.
- Response with count==0:
  - rsp_valid=0 and the response is dropped.
  - rsp_error<=1 and stays set until reset.
  - A push in the same cycle does not satisfy it.
- Requester rule: ports must hold req_valid and payload stable until req_ready. The arbiter never grants a port whose req_valid=0.
- Reset mid-operation: all state clears immediately. In-flight memory transactions are forgotten, and their later responses raise rsp_error.

Optional Feature:
- Macro MISS_ARB_PERF_CNT_EN.
- Defined:
  - Adds output perf_grant_cnt (NUM_PORTS*32): per-port saturating 32-bit counters of grants.
  - Adds output perf_full_stall_cnt (32): saturating count of cycles with any req_valid set while the FIFO is full.
  - All counters reset to 0.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Single request: port1 requests addr 0x0000_1040 load, mem_req_ready=1 at first opportunity.
  -> req_ready=2'b10 in cycle N; mem_req_valid, addr 0x1040, id=1 in N+1; mem_rsp_valid with data 0xAA..AA gives rsp_valid=2'b10.
- Round-robin: both ports hold req_valid continuously, memory always ready.
  -> grants alternate 0,1,0,1; rsp_valid routes in the same order for four in-order responses.
- Backpressure: mem_req_ready=0 for 5 cycles after a grant.
  -> mem_req_* stable for 5 cycles; no new req_ready until one cycle after acceptance.
- FIFO full: OUTSTANDING=4, issue 4 requests with no responses.
  -> 5th request sees req_ready=0; one response frees a slot and the request is granted in the following IDLE cycle.
- Spurious response: mem_rsp_valid=1 with count=0.
  -> rsp_valid=0; rsp_error=1 next cycle and stays 1; async reset low clears it without waiting for a clock edge.
- NUM_PORTS=3 with ports 0 and 2 valid, rr_ptr=1.
  -> port 2 granted first, then port 0.
